uart_cmd_ctrl: RTL and testbench

UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

---
 rtl/uart_cmd_ctrl_pkg.sv | 22 ++
 rtl/uart_timeout_ctr.sv | 29 ++
 rtl/uart_cmd_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared types and constants for the UART command controller.
package uart_cmd_ctrl_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 32;

  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;
  localparam logic [BYTE_W-1:0] ACK_BYTE  = 8'h06;
  localparam logic [BYTE_W-1:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_DISPATCH,
    ST_RESP,
    ST_RESP_WAIT
  } state_t;

endpackage

// File: rtl/uart_timeout_ctr.sv
// Inter-byte timeout counter: cleared on reload or while disabled, one-cycle expire.
module uart_timeout_ctr #(
  parameter int unsigned TIMEOUT_CLKS = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic enable,
  output logic expire_c
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  logic [CNT_W-1:0] cnt;

  // A reload in the same cycle suppresses expiry so the byte wins.
  assign expire_c = enable && !reload && (cnt == CNT_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (reload || !enable || expire_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame decoder for SYNC/OPCODE/LEN/payload/CSUM commands with ACK/NAK response.
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 250000,
  parameter int unsigned MAX_LEN      = 4
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_RX_DV,
  input  logic [7:0]  i_RX_Byte,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  input  logic        i_TX_Active,
  input  logic        i_TX_Done,
  output logic        o_Cmd_Valid,
  output logic [7:0]  o_Cmd_Opcode,
  output logic [31:0] o_Cmd_Data,
  input  logic        i_Cmd_Ready,
  output logic        o_Busy,
  output logic        o_Err
);

  state_t              state, state_n;
  logic [BYTE_W-1:0]   opcode, opcode_n;
  logic [DATA_W-1:0]   data, data_n;
  logic [BYTE_W-1:0]   len, len_n;
  logic [BYTE_W-1:0]   idx, idx_n;
  logic [BYTE_W-1:0]   csum, csum_n;
  logic [BYTE_W-1:0]   resp, resp_n;
  logic [BYTE_W-1:0]   tx_byte, tx_byte_n;
  logic                tx_dv, tx_dv_n;
  logic                cmd_valid, cmd_valid_n;
  logic                busy, busy_n;
  logic                err, err_n;
  logic                tmo_en_c;
  logic                tmo_expire_c;

  assign tmo_en_c = (state == ST_OPC) || (state == ST_LEN) ||
                    (state == ST_DATA) || (state == ST_CSUM);

  uart_timeout_ctr #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clk      (i_Clk),
    .rst      (i_Rst),
    .reload   (i_RX_DV),
    .enable   (tmo_en_c),
    .expire_c (tmo_expire_c)
  );

  // State and output registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state     <= ST_IDLE;
      opcode    <= '0;
      data      <= '0;
      len       <= '0;
      idx       <= '0;
      csum      <= '0;
      resp      <= '0;
      tx_byte   <= '0;
      tx_dv     <= 1'b0;
      cmd_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      opcode    <= opcode_n;
      data      <= data_n;
      len       <= len_n;
      idx       <= idx_n;
      csum      <= csum_n;
      resp      <= resp_n;
      tx_byte   <= tx_byte_n;
      tx_dv     <= tx_dv_n;
      cmd_valid <= cmd_valid_n;
      busy      <= busy_n;
      err       <= err_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    opcode_n  = opcode;
    data_n    = data;
    len_n     = len;
    idx_n     = idx;
    csum_n    = csum;
    resp_n    = resp;
    tx_byte_n = tx_byte;
    tx_dv_n   = 1'b0;
    err_n     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
          state_n = ST_OPC;
          data_n  = '0;
        end
      end
      ST_OPC: begin
        if (i_RX_DV) begin
          opcode_n = i_RX_Byte;
          csum_n   = i_RX_Byte;
          state_n  = ST_LEN;
        end else if (tmo_expire_c) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_LEN: begin
        if (i_RX_DV) begin
          len_n  = i_RX_Byte;
          csum_n = csum ^ i_RX_Byte;
          idx_n  = '0;
          if (i_RX_Byte > BYTE_W'(MAX_LEN)) begin
            resp_n  = NAK_BYTE;
            err_n   = 1'b1;
            state_n = ST_RESP;
          end else if (i_RX_Byte == '0) begin
            state_n = ST_CSUM;
          end else begin
            state_n = ST_DATA;
          end
        end else if (tmo_expire_c) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_DATA: begin
        if (i_RX_DV) begin
          data_n[{idx[1:0], 3'b000} +: BYTE_W] = i_RX_Byte;
          csum_n = csum ^ i_RX_Byte;
          idx_n  = idx + BYTE_W'(1);
          if (idx == (len - BYTE_W'(1))) begin
            state_n = ST_CSUM;
          end
        end else if (tmo_expire_c) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_CSUM: begin
        if (i_RX_DV) begin
          if (i_RX_Byte == csum) begin
            state_n = ST_DISPATCH;
          end else begin
            resp_n  = NAK_BYTE;
            err_n   = 1'b1;
            state_n = ST_RESP;
          end
        end else if (tmo_expire_c) begin
          state_n = ST_IDLE;
          err_n   = 1'b1;
        end
      end
      ST_DISPATCH: begin
        err_n = i_RX_DV;
        if (cmd_valid && i_Cmd_Ready) begin
          resp_n  = ACK_BYTE;
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        err_n = i_RX_DV;
        if (!i_TX_Active) begin
          tx_dv_n   = 1'b1;
          tx_byte_n = resp;
          state_n   = ST_RESP_WAIT;
        end
      end
      ST_RESP_WAIT: begin
        err_n = i_RX_DV;
        if (i_TX_Done) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    cmd_valid_n = (state_n == ST_DISPATCH);
    busy_n      = (state_n != ST_IDLE);
  end

  assign o_TX_DV      = tx_dv;
  assign o_TX_Byte    = tx_byte;
  assign o_Cmd_Valid  = cmd_valid;
  assign o_Cmd_Opcode = opcode;
  assign o_Cmd_Data   = data;
  assign o_Busy       = busy;
  assign o_Err        = err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed self-checking bench for uart_cmd_ctrl.
module tb_uart_cmd_ctrl;

  localparam int unsigned TMO = 40;

  logic        i_Clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic        i_RX_DV = 1'b0;
  logic [7:0]  i_RX_Byte = 8'h00;
  logic        o_TX_DV;
  logic [7:0]  o_TX_Byte;
  logic        i_TX_Active = 1'b0;
  logic        i_TX_Done = 1'b0;
  logic        o_Cmd_Valid;
  logic [7:0]  o_Cmd_Opcode;
  logic [31:0] o_Cmd_Data;
  logic        i_Cmd_Ready = 1'b1;
  logic        o_Busy;
  logic        o_Err;

  int n_cmp = 0;
  int n_bad = 0;

  int err_total = 0;
  int txdv_total = 0;
  int valid_total = 0;
  logic [7:0]  last_op = 8'h00;
  logic [31:0] last_data = 32'h0;

  int err0, txdv0, valid0;

  uart_cmd_ctrl #(
    .TIMEOUT_CLKS(TMO),
    .MAX_LEN(4)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_RX_DV     (i_RX_DV),
    .i_RX_Byte   (i_RX_Byte),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active),
    .i_TX_Done   (i_TX_Done),
    .o_Cmd_Valid (o_Cmd_Valid),
    .o_Cmd_Opcode(o_Cmd_Opcode),
    .o_Cmd_Data  (o_Cmd_Data),
    .i_Cmd_Ready (i_Cmd_Ready),
    .o_Busy      (o_Busy),
    .o_Err       (o_Err)
  );

  always #5 i_Clk = ~i_Clk;

  // Event monitor, sampled on the falling edge.
  always @(negedge i_Clk) begin
    if (o_Err) err_total = err_total + 1;
    if (o_TX_DV) txdv_total = txdv_total + 1;
    if (o_Cmd_Valid) begin
      valid_total = valid_total + 1;
      last_op     = o_Cmd_Opcode;
      last_data   = o_Cmd_Data;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge i_Clk);
    i_RX_DV   = 1'b1;
    i_RX_Byte = b;
    @(negedge i_Clk);
    i_RX_DV   = 1'b0;
  endtask

  task automatic snap();
    @(negedge i_Clk);
    err0   = err_total;
    txdv0  = txdv_total;
    valid0 = valid_total;
  endtask

  // Wait for the response pulse, check it, then play the transmitter side.
  task automatic complete_resp(input string tag, input logic [7:0] exp_byte, input int bound);
    int found;
    found = 0;
    for (int i = 0; i < bound && found == 0; i++) begin
      @(negedge i_Clk);
      if (o_TX_DV) found = 1;
    end
    check_eq({tag, "_txdv_seen"}, 32'(found), 32'd1);
    if (found != 0) begin
      check_eq({tag, "_tx_byte"}, {24'h0, o_TX_Byte}, {24'h0, exp_byte});
      i_TX_Active = 1'b1;
      repeat (3) @(negedge i_Clk);
      i_TX_Active = 1'b0;
      i_TX_Done   = 1'b1;
      @(negedge i_Clk);
      i_TX_Done   = 1'b0;
      @(negedge i_Clk);
      check_eq({tag, "_idle_after"}, {31'h0, o_Busy}, 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge i_Clk);
    check_eq("rst_tx_dv",   {31'h0, o_TX_DV}, 32'd0);
    check_eq("rst_tx_byte", {24'h0, o_TX_Byte}, 32'd0);
    check_eq("rst_valid",   {31'h0, o_Cmd_Valid}, 32'd0);
    check_eq("rst_opcode",  {24'h0, o_Cmd_Opcode}, 32'd0);
    check_eq("rst_data",    o_Cmd_Data, 32'd0);
    check_eq("rst_busy",    {31'h0, o_Busy}, 32'd0);
    check_eq("rst_err",     {31'h0, o_Err}, 32'd0);
    i_Rst = 1'b0;

    // Non-sync bytes in IDLE are ignored silently.
    snap();
    send_byte(8'h33);
    send_byte(8'h06);
    @(negedge i_Clk);
    check_eq("idle_noise_busy", {31'h0, o_Busy}, 32'd0);
    check_eq("idle_noise_err", 32'(err_total - err0), 32'd0);

    // Good frame: checksum 10^02^34^12 = 34.
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h34);
    complete_resp("good", 8'h06, 10);
    check_eq("good_valid_cnt", 32'(valid_total - valid0), 32'd1);
    check_eq("good_opcode", {24'h0, last_op}, 32'h10);
    check_eq("good_data", last_data, 32'h0000_1234);
    check_eq("good_err", 32'(err_total - err0), 32'd0);

    // Bad checksum.
    snap();
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h34); send_byte(8'h12); send_byte(8'h35);
    complete_resp("badcs", 8'h15, 10);
    check_eq("badcs_valid_cnt", 32'(valid_total - valid0), 32'd0);
    check_eq("badcs_err", 32'(err_total - err0), 32'd1);

    // Length above MAX_LEN: NAK without waiting for payload.
    snap();
    send_byte(8'hA5); send_byte(8'h20); send_byte(8'h05);
    complete_resp("badlen", 8'h15, 3);
    check_eq("badlen_err", 32'(err_total - err0), 32'd1);
    check_eq("badlen_valid_cnt", 32'(valid_total - valid0), 32'd0);

    // Timeout after opcode.
    snap();
    send_byte(8'hA5); send_byte(8'h10);
    repeat (TMO - 3) @(negedge i_Clk);
    check_eq("tmo_early_busy", {31'h0, o_Busy}, 32'd1);
    check_eq("tmo_early_err", 32'(err_total - err0), 32'd0);
    repeat (6) @(negedge i_Clk);
    check_eq("tmo_err", 32'(err_total - err0), 32'd1);
    check_eq("tmo_busy", {31'h0, o_Busy}, 32'd0);
    check_eq("tmo_no_tx", 32'(txdv_total - txdv0), 32'd0);

    // Backpressure: checksum 33^01^5A = 68.
    i_Cmd_Ready = 1'b0;
    snap();
    send_byte(8'hA5); send_byte(8'h33); send_byte(8'h01);
    send_byte(8'h5A); send_byte(8'h68);
    for (int c = 0; c < 50; c++) begin
      @(negedge i_Clk);
      if (c % 10 == 5) begin
        check_eq("bp_valid", {31'h0, o_Cmd_Valid}, 32'd1);
        check_eq("bp_data", o_Cmd_Data, 32'h0000_005A);
        check_eq("bp_opcode", {24'h0, o_Cmd_Opcode}, 32'h33);
      end
      if (c == 20) begin
        i_RX_DV = 1'b1;
        i_RX_Byte = 8'hFF;
      end else begin
        i_RX_DV = 1'b0;
      end
    end
    check_eq("bp_inject_err", 32'(err_total - err0), 32'd1);
    check_eq("bp_still_valid", {31'h0, o_Cmd_Valid}, 32'd1);
    check_eq("bp_no_tx", 32'(txdv_total - txdv0), 32'd0);
    i_Cmd_Ready = 1'b1;
    complete_resp("bp", 8'h06, 10);
    check_eq("bp_valid_drop", {31'h0, o_Cmd_Valid}, 32'd0);

    // Asynchronous reset in the middle of DATA.
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h04);
    send_byte(8'h11); send_byte(8'h22);
    check_eq("mid_data", o_Cmd_Data, 32'h0000_2211);
    check_eq("mid_busy", {31'h0, o_Busy}, 32'd1);
    #2 i_Rst = 1'b1;
    #1;
    check_eq("arst_data", o_Cmd_Data, 32'd0);
    check_eq("arst_busy", {31'h0, o_Busy}, 32'd0);
    check_eq("arst_opcode", {24'h0, o_Cmd_Opcode}, 32'd0);
    repeat (2) @(negedge i_Clk);
    i_Rst = 1'b0;
    snap();
    send_byte(8'hA5); send_byte(8'h07); send_byte(8'h00); send_byte(8'h07);
    complete_resp("post_rst", 8'h06, 10);
    check_eq("post_rst_valid_cnt", 32'(valid_total - valid0), 32'd1);
    check_eq("post_rst_opcode", {24'h0, last_op}, 32'h07);
    check_eq("post_rst_data", last_data, 32'd0);
    check_eq("post_rst_err", 32'(err_total - err0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
